text_reveal_rom: RTL and testbench

Parametrised multi-page character ROM with a timed "typewriter" reveal, feeding the 16x16-cell text overlay of the labyrinth display.
- Holds PAGES fixed messages: page 0 is the instructions text, page 1 is the congratulations text, further pages are spare.
- After a start pulse, characters of the selected page appear one at a time, paced by an external frame tick.
- Sits between the game-stage controller (page_sel, start, skip) and the font-ROM/draw-text pipeline (char_yx in, char_code out).

---
 rtl/text_reveal_rom_pkg.sv | 70 +++++++
 rtl/text_reveal_rom_if.sv | 30 +++
 rtl/text_page_rom.sv | 19 +
 rtl/text_reveal_rom.sv | 115 +++++++++++
 tb/tb_text_reveal_rom.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_reveal_rom_pkg.sv
// Shared types, page lengths and message tables for the typewriter text overlay.
// Messages are laid out as 16-character rows; rom_char flattens (page, addr) to a byte.
package text_reveal_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    HOLD   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_BLANK = 2'd0,
    SEL_SPACE = 2'd1,
    SEL_ROM   = 2'd2
  } mask_e;

  localparam int unsigned LEN0     = 246;
  localparam int unsigned LEN1     = 33;
  localparam int unsigned MSG_COLS = 16;
  localparam logic [7:0]  SPACE    = 8'h20;
  localparam logic [7:0]  BLANK    = 8'h00;

  function automatic int unsigned page_len(input int unsigned page);
    if (page == 0) return LEN0;
    else if (page == 1) return LEN1;
    else return 0;
  endfunction

  function automatic logic [127:0] msg_row(input int unsigned page, input int unsigned row);
    logic [127:0] r;
    r = {16{SPACE}};
    if (page == 0) begin
      case (row)
        0:  r = {"WELCOME TO THE", {2{SPACE}}};
        1:  r = {"LABYRINTH. FIND", SPACE};
        2:  r = {"THE WAY OUT OF", {2{SPACE}}};
        3:  r = {"THE MAZE BEFORE", SPACE};
        4:  r = {"TIME RUNS OUT.", {2{SPACE}}};
        5:  r = {"USE THE ARROW", {3{SPACE}}};
        6:  r = {"KEYS TO MOVE UP", SPACE};
        7:  r = {"DOWN LEFT AND", {3{SPACE}}};
        8:  r = "RIGHT. WALLS ARE";
        9:  r = {"SOLID. FIND THE", SPACE};
        10: r = {"GOLDEN KEY TO", {3{SPACE}}};
        11: r = {"OPEN THE EXIT", {3{SPACE}}};
        12: r = {"DOOR. PRESS ANY", SPACE};
        13: r = "KEY TO START THE";
        14: r = {"GAME. GOOD LUCK", SPACE};
        15: r = {"ENJOY.", {10{SPACE}}};
        default: r = {16{SPACE}};
      endcase
    end else if (page == 1) begin
      // CP437 0x13 (double exclamation) and 0x01 (smiley) end the message
      case (row)
        0: r = "CONGRATULATIONS!";
        1: r = {" YOU ARE FREE", SPACE, 8'h13, SPACE};
        2: r = {8'h01, {15{SPACE}}};
        default: r = {16{SPACE}};
      endcase
    end
    return r;
  endfunction

  function automatic logic [7:0] rom_char(input int unsigned page, input int unsigned addr);
    logic [127:0] r;
    r = msg_row(page, addr / MSG_COLS);
    return r[8*(MSG_COLS - 1 - (addr % MSG_COLS)) +: 8];
  endfunction

endpackage

// File: rtl/text_reveal_rom_if.sv
// Control and character-lookup bundle between the stage controller / text drawer and the reveal ROM.
interface text_reveal_rom_if #(
  parameter int unsigned COLS   = 16,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned PAGES  = 2,
  parameter int unsigned CODE_W = 7
);
  localparam int unsigned ADDR_W = $clog2(COLS * ROWS);
  localparam int unsigned PSEL_W = (PAGES > 1) ? $clog2(PAGES) : 1;

  logic [PSEL_W-1:0] page_sel;
  logic              start;
  logic              skip;
  logic              tick;
  logic [ADDR_W-1:0] char_yx;
  logic [CODE_W-1:0] char_code;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   reveal_cnt;

  modport master (
    output page_sel, start, skip, tick, char_yx,
    input  char_code, busy, done, reveal_cnt
  );

  modport slave (
    input  page_sel, start, skip, tick, char_yx,
    output char_code, busy, done, reveal_cnt
  );
endinterface

// File: rtl/text_page_rom.sv
// Registered message lookup: code_p1 is the character at (page, addr) from the previous cycle.
module text_page_rom
  import text_reveal_pkg::*;
#(
  parameter int unsigned PSEL_W = 1,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CODE_W = 7
) (
  input  logic              pclk,
  input  logic [PSEL_W-1:0] page,
  input  logic [ADDR_W-1:0] addr,
  output logic [CODE_W-1:0] code_p1
);

  always_ff @(posedge pclk) begin
    code_p1 <= CODE_W'(rom_char(32'(page), 32'(addr)));
  end

endmodule

// File: rtl/text_reveal_rom.sv
// Typewriter reveal of a stored text page: FSM, tick divider, reveal counter and
// an output mask registered alongside the ROM lookup so both share one cycle of latency.
module text_reveal_rom
  import text_reveal_pkg::*;
#(
  parameter int unsigned COLS       = 16,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned PAGES      = 2,
  parameter int unsigned CODE_W     = 7,
  parameter int unsigned CHAR_DELAY = 4
) (
  input  logic pclk,
  input  logic rst_n,
  text_reveal_rom_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(COLS * ROWS);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned PSEL_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned DIV_W  = $clog2(CHAR_DELAY) + 1;

  state_e            state;
  logic [PSEL_W-1:0] page_q;
  logic [PSEL_W-1:0] page_pick;
  logic [CNT_W-1:0]  reveal_cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  cur_len;
  logic [CNT_W-1:0]  sel_len;
  logic [CNT_W-1:0]  addr_ext;
  logic [DIV_W-1:0]  div_q;
  logic              busy_q;
  logic              done_q;
  mask_e             mask_d;
  mask_e             mask_p1;
  logic [CODE_W-1:0] rom_code_p1;

  always_comb begin
    page_pick = '0;
    if (32'(bus.page_sel) < PAGES) page_pick = bus.page_sel;
    sel_len  = CNT_W'(page_len(32'(page_pick)));
    cur_len  = CNT_W'(page_len(32'(page_q)));
    addr_ext = CNT_W'(bus.char_yx);
    cnt_inc  = reveal_cnt_q + CNT_W'(1);
    mask_d   = SEL_SPACE;
    if (state == IDLE || addr_ext >= cur_len) mask_d = SEL_BLANK;
    else if (addr_ext < reveal_cnt_q)         mask_d = SEL_ROM;
  end

  // Stage p0 -> p1: mask is captured on the same edge as the ROM lookup
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      page_q       <= '0;
      reveal_cnt_q <= '0;
      div_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mask_p1      <= SEL_BLANK;
    end else begin
      done_q  <= 1'b0;
      mask_p1 <= mask_d;
      if (bus.start) begin
        page_q       <= page_pick;
        reveal_cnt_q <= '0;
        div_q        <= '0;
        if (sel_len == '0) begin
          state  <= HOLD;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          state  <= REVEAL;
          busy_q <= 1'b1;
        end
      end else if (state == REVEAL) begin
        if (bus.skip) begin
          reveal_cnt_q <= cur_len;
          state        <= HOLD;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
        end else if (bus.tick) begin
          if (div_q == DIV_W'(CHAR_DELAY - 1)) begin
            div_q        <= '0;
            reveal_cnt_q <= cnt_inc;
            // reaching the page length ends the reveal, so the count cannot pass LEN
            if (cnt_inc == cur_len) begin
              state  <= HOLD;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
      end
    end
  end

  text_page_rom #(
    .PSEL_W (PSEL_W),
    .ADDR_W (ADDR_W),
    .CODE_W (CODE_W)
  ) u_page_rom (
    .pclk    (pclk),
    .page    (page_q),
    .addr    (bus.char_yx),
    .code_p1 (rom_code_p1)
  );

  assign bus.char_code  = (mask_p1 == SEL_ROM)   ? rom_code_p1 :
                          (mask_p1 == SEL_SPACE) ? CODE_W'(SPACE) : CODE_W'(BLANK);
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.reveal_cnt = reveal_cnt_q;

endmodule

// File: tb/tb_text_reveal_rom.sv
// Directed bench for text_reveal_rom: a tick-counting reveal model checked every cycle,
// plus literal expectations for the characters and counts at key points.
module tb_text_reveal_rom;

  localparam int unsigned PAGES = 3;
  localparam int          CD    = 2;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  text_reveal_rom_if #(.PAGES(PAGES)) bus_if ();

  text_reveal_rom #(
    .PAGES      (PAGES),
    .CHAR_DELAY (CD)
  ) dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  byte unsigned tbl [PAGES][256];

  // Model: a page is active after start; revealed = accepted ticks / CD, capped at LEN, or LEN after skip
  bit m_active = 1'b0;
  int m_page   = 0;
  int m_ticks  = 0;
  bit m_skip   = 1'b0;
  bit m_done   = 1'b0;
  int m_code   = 0;
  bit run_cmp  = 1'b0;

  function automatic int len_of(input int p);
    if (p == 0) return 246;
    if (p == 1) return 33;
    return 0;
  endfunction

  function automatic int revealed();
    int r;
    if (!m_active) return 0;
    if (m_skip) return len_of(m_page);
    r = m_ticks / CD;
    return (r > len_of(m_page)) ? len_of(m_page) : r;
  endfunction

  function automatic bit in_reveal();
    return m_active && (revealed() < len_of(m_page));
  endfunction

  function automatic int exp_char(input int addr);
    if (!m_active || addr >= len_of(m_page)) return 0;
    if (addr < revealed()) return int'(tbl[m_page][addr]);
    return 'h20;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int p, input int row, input string s);
    for (int i = 0; i < s.len(); i++) tbl[p][row*16+i] = s.getc(i);
  endtask

  initial forever begin
    @(posedge pclk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0; m_page = 0; m_ticks = 0; m_skip = 1'b0; m_done = 1'b0; m_code = 0;
    end else begin
      m_code = exp_char(int'(bus_if.char_yx));
      m_done = 1'b0;
      if (bus_if.start) begin
        m_active = 1'b1;
        m_page   = (int'(bus_if.page_sel) < int'(PAGES)) ? int'(bus_if.page_sel) : 0;
        m_ticks  = 0;
        m_skip   = 1'b0;
        if (len_of(m_page) == 0) m_done = 1'b1;
      end else if (in_reveal()) begin
        if (bus_if.skip) begin
          m_skip = 1'b1;
          m_done = 1'b1;
        end else if (bus_if.tick) begin
          m_ticks++;
          if (!in_reveal()) m_done = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge pclk);
    if (run_cmp) begin
      chk("model_char_code", int'(bus_if.char_code), m_code);
      chk("model_busy", int'(bus_if.busy), int'(in_reveal()));
      chk("model_done", int'(bus_if.done), int'(m_done));
      chk("model_reveal_cnt", int'(bus_if.reveal_cnt), revealed());
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_start(input int p);
    bus_if.page_sel = p[1:0];
    bus_if.start    = 1'b1;
    step();
    bus_if.start    = 1'b0;
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.tick = 1'b1;
      step();
    end
    bus_if.tick = 1'b0;
  endtask

  task automatic look(input int a, input int exp, input string nm);
    bus_if.char_yx = a[7:0];
    step();
    chk(nm, int'(bus_if.char_code), exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < int'(PAGES); p++)
      for (int a = 0; a < 256; a++) tbl[p][a] = 8'h20;
    load(0, 0,  "WELCOME TO THE");
    load(0, 1,  "LABYRINTH. FIND");
    load(0, 2,  "THE WAY OUT OF");
    load(0, 3,  "THE MAZE BEFORE");
    load(0, 4,  "TIME RUNS OUT.");
    load(0, 5,  "USE THE ARROW");
    load(0, 6,  "KEYS TO MOVE UP");
    load(0, 7,  "DOWN LEFT AND");
    load(0, 8,  "RIGHT. WALLS ARE");
    load(0, 9,  "SOLID. FIND THE");
    load(0, 10, "GOLDEN KEY TO");
    load(0, 11, "OPEN THE EXIT");
    load(0, 12, "DOOR. PRESS ANY");
    load(0, 13, "KEY TO START THE");
    load(0, 14, "GAME. GOOD LUCK");
    load(0, 15, "ENJOY.");
    load(1, 0,  "CONGRATULATIONS!");
    load(1, 1,  " YOU ARE FREE");
    tbl[1][30] = 8'h13;
    tbl[1][32] = 8'h01;

    bus_if.page_sel = '0;
    bus_if.start    = 1'b0;
    bus_if.skip     = 1'b0;
    bus_if.tick     = 1'b0;
    bus_if.char_yx  = '0;
    rst_n = 1'b0;
    repeat (3) step();
    run_cmp = 1'b1;

    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_done", int'(bus_if.done), 0);
    chk("rst_cnt", int'(bus_if.reveal_cnt), 0);
    chk("rst_code", int'(bus_if.char_code), 0);
    for (int a = 0; a < 256; a++) look(a, 0, "rst_sweep");
    rst_n = 1'b1;
    step();
    step();

    do_start(1);
    chk("start_busy", int'(bus_if.busy), 1);
    chk("start_cnt", int'(bus_if.reveal_cnt), 0);
    do_tick(2);
    chk("basic_cnt1", int'(bus_if.reveal_cnt), 1);
    look(8'h00, 8'h43, "basic_C");
    look(8'h01, 8'h20, "basic_space");
    look(8'h21, 8'h00, "basic_beyond_len");

    do_tick(63);
    chk("pre_done_cnt", int'(bus_if.reveal_cnt), 32);
    chk("pre_done_done", int'(bus_if.done), 0);
    do_tick(1);
    chk("cmpl_cnt", int'(bus_if.reveal_cnt), 33);
    chk("cmpl_done", int'(bus_if.done), 1);
    chk("cmpl_busy", int'(bus_if.busy), 0);
    step();
    chk("cmpl_done_once", int'(bus_if.done), 0);
    look(8'h1E, 8'h13, "cmpl_dblexcl");
    look(8'h20, 8'h01, "cmpl_smiley");
    do_tick(4);
    chk("hold_cnt", int'(bus_if.reveal_cnt), 33);

    do_start(0);
    do_tick(3);
    chk("skip_pre_cnt", int'(bus_if.reveal_cnt), 1);
    bus_if.skip = 1'b1;
    step();
    bus_if.skip = 1'b0;
    chk("skip_cnt", int'(bus_if.reveal_cnt), 246);
    chk("skip_done", int'(bus_if.done), 1);
    chk("skip_busy", int'(bus_if.busy), 0);
    look(8'hF5, 8'h2E, "skip_last");
    look(8'hF6, 8'h00, "skip_beyond");
    bus_if.skip = 1'b1;
    step();
    bus_if.skip = 1'b0;
    chk("skip_hold_done", int'(bus_if.done), 0);
    chk("skip_hold_cnt", int'(bus_if.reveal_cnt), 246);

    bus_if.char_yx  = '0;
    bus_if.page_sel = 2'd3;
    bus_if.start    = 1'b1;
    bus_if.tick     = 1'b1;
    step();
    bus_if.start = 1'b0;
    bus_if.tick  = 1'b0;
    chk("coll_cnt", int'(bus_if.reveal_cnt), 0);
    chk("coll_busy", int'(bus_if.busy), 1);
    step();
    chk("coll_space", int'(bus_if.char_code), 8'h20);
    do_tick(1);
    chk("coll_div0", int'(bus_if.reveal_cnt), 0);
    do_tick(1);
    chk("coll_cnt1", int'(bus_if.reveal_cnt), 1);
    step();
    chk("coll_W", int'(bus_if.char_code), 8'h57);

    do_start(2);
    chk("empty_done", int'(bus_if.done), 1);
    chk("empty_busy", int'(bus_if.busy), 0);
    step();
    chk("empty_done_once", int'(bus_if.done), 0);
    look(0, 8'h00, "empty_blank");

    do_start(0);
    do_tick(20);
    chk("mid_cnt10", int'(bus_if.reveal_cnt), 10);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_rst_cnt", int'(bus_if.reveal_cnt), 0);
      chk("mid_rst_busy", int'(bus_if.busy), 0);
      chk("mid_rst_done", int'(bus_if.done), 0);
      chk("mid_rst_code", int'(bus_if.char_code), 0);
    end
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_busy", int'(bus_if.busy), 0);
    do_start(1);
    chk("restart_cnt", int'(bus_if.reveal_cnt), 0);
    chk("restart_busy", int'(bus_if.busy), 1);
    do_tick(2);
    chk("restart_cnt1", int'(bus_if.reveal_cnt), 1);
    step();

    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
